cr_huf_comp_st_seq: RTL and testbench
=====================================

// Module: cr_huf_comp_st_seq
// PURPOSE
//  Parametrised successor to the single-table ST handoff FSM. Tracks NUM_BUF symbol-table
//  buffers, each running IDLE->START_STCL->RDY_TO_SA->TBL_RDY_TO_SA->IDLE independently.
//  Tree-walk (tw) fills buffer k while the SA stage still reads buffer k-1. Adds an in-order
//  read pointer, an occupancy count, a per-buffer STCL watchdog and sticky protocol errors.
// PARAMETERS
//  NUM_BUF   2    number of table buffers (>=1; 1 reproduces the single-table FSM)
//  IDX_W     $clog2(NUM_BUF) or 1, whichever is larger; buffer index width
//  TMO_W     16   watchdog counter width
//  TMO_CYC   4096 cycles allowed in START_STCL before timeout; 0 = watchdog off
// PORTS
//  clk                 in   1              clock
//  rst_n               in   1              async active-low reset
//  tw_pass_thru_rdy    in   1              alloc request, pass-thru (no STCL phase)
//  tw_code_rdy         in   1              alloc request, coded (STCL phase needed)
//  st_stcl_lut_wr_done in   1              STCL LUT write done for buffer st_stcl_idx
//  st_stcl_idx         in   IDX_W          buffer index for stcl done
//  st_st_lut_wr_done   in   1              ST LUT write done for buffer st_st_idx
//  st_st_idx           in   IDX_W          buffer index for st done
//  sa_st_read_done     in   1              SA finished with buffer st_rd_idx
//  st_rdy              out  1              buffer at st_wr_idx is IDLE; alloc accepted
//  st_wr_idx           out  IDX_W          next buffer to allocate
//  st_rd_idx           out  IDX_W          buffer SA owns/reads next
//  st_sa_vld           out  1              st_rd_idx in RDY_TO_SA or TBL_RDY_TO_SA
//  st_sa_tbl_vld       out  1              st_rd_idx in TBL_RDY_TO_SA
//  st_occ              out  IDX_W+1        buffers not IDLE
//  st_curr_st          out  NUM_BUF x e_st_state   per-buffer current state
//  st_err_tmo          out  1              sticky: a buffer exceeded TMO_CYC in START_STCL
//  st_err_proto        out  1              sticky: done/read in an illegal state
// BEHAVIOUR
//  - Reset: all buffers ST_IDLE, wr/rd idx 0, occ 0, errs 0, counters 0; st_rdy=1, vld=0.
//  - Alloc: tw_pass_thru_rdy|tw_code_rdy with st_rdy -> buffer[wr] next state RDY_TO_SA
//    (pass_thru) or START_STCL (code); wr_idx++ (wrap NUM_BUF-1->0). Pass_thru wins if both.
//    A request while st_rdy=0 is ignored, not an error. tw holds its request until st_rdy.
//  - START_STCL & stcl_done(idx) -> RDY_TO_SA. RDY_TO_SA & st_done(idx) -> TBL_RDY_TO_SA.
//  - sa_st_read_done: buffer[rd] in RDY_TO_SA or TBL_RDY_TO_SA -> IDLE, rd_idx++.
//    Read wins over st_done on the same buffer in the same cycle, as in the single-table FSM.
//  - Illegal events set st_err_proto; state is unchanged:
//    stcl_done not in START_STCL; st_done not in RDY_TO_SA; read_done with st_sa_vld=0.
//  - Outputs are registered state decodes, 1-cycle latency. An event in cycle n is visible
//    in n+1. A buffer freed in cycle n can be re-allocated in n+1. No combinational
//    in->out path except none: all outputs are derived from flops.
//  - Simultaneous events on different buffers (alloc, stcl, st, read) all apply in one cycle.
//  - st_occ: +1 on alloc, -1 on read, net 0 when both occur.
//  - Watchdog: counter[k] clears on entry to START_STCL and increments while there,
//    saturating at TMO_CYC. At ==TMO_CYC, st_err_tmo sets; the buffer stays in START_STCL.
//  - Sticky errors clear only on rst_n. Reset mid-operation aborts all buffers to IDLE async.
// STRUCTURE
//  - Package cr_huf_compPKG holds e_st_state (ST_IDLE, START_STCL, RDY_TO_SA,
//    TBL_RDY_TO_SA). Also add ST_SEQ_NUM_BUF_DFLT and ST_SEQ_TMO_DFLT there.
//  - Sub-module cr_huf_comp_st_slot: one per buffer via generate. Each holds the state
//    flop, the watchdog counter and a proto-error pulse. Inputs are decoded per-slot
//    strobes (alloc_pt, alloc_code, stcl, st, rd).
//  - The top holds wr/rd pointers, occupancy, strobe decode and OR/sticky of errors.
// TESTING
//  1 NUM_BUF=1: code_rdy, stcl_done, st_done, read_done -> states
//    START_STCL,RDY_TO_SA,TBL_RDY_TO_SA,IDLE on successive cycles; occ 1,1,1,0.
//  2 NUM_BUF=2: pass_thru x2, 3rd request held -> st_rdy=0 after 2nd, occ=2.
//    read_done frees buf0 -> st_rdy=1 next cycle, 3rd alloc lands in buf0, wr_idx wraps to 1.
//  3 Same cycle on buf0 RDY_TO_SA: read_done & st_done(0) -> buf0 IDLE, no error, rd_idx=1.
//  4 TMO_CYC=8: code_rdy, no stcl_done -> st_err_tmo=1 exactly 8 cycles after entry.
//    It stays 1; stcl_done later still moves the buffer to RDY_TO_SA.
//  5 stcl_done(1) while buf1 IDLE -> st_err_proto=1, no state change.
//    read_done with st_sa_vld=0 -> same.
//  6 NUM_BUF=4: random legal traffic with rst_n pulsed mid-stream -> all outputs at reset
//    values the same cycle. Scoreboard checks in-order reads and occ == count(non-IDLE).

Source files
------------

// File: rtl/cr_huf_comp_st_seq_pkg.sv
`default_nettype none
// ============================================================================
// cr_huf_compPKG : shared types for the multi-buffer symbol-table sequencer
// Revision: 1.0
// ============================================================================
package cr_huf_compPKG;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        START_STCL    = 2'd1,
        RDY_TO_SA     = 2'd2,
        TBL_RDY_TO_SA = 2'd3
    } e_st_state;

    localparam int ST_SEQ_NUM_BUF_DFLT = 2;
    localparam int ST_SEQ_TMO_DFLT     = 4096;

endpackage
`default_nettype wire

// File: rtl/cr_huf_comp_st_slot.sv
`default_nettype none
// ============================================================================
// cr_huf_comp_st_slot : one symbol-table buffer state, watchdog and error pulse
// Revision: 1.0
// ============================================================================
module cr_huf_comp_st_slot
    import cr_huf_compPKG::*;
#(
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = ST_SEQ_TMO_DFLT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      alloc_pt_i,
    input  logic      alloc_code_i,
    input  logic      stcl_i,
    input  logic      st_i,
    input  logic      rd_i,
    output e_st_state state_o,
    output logic      tmo_o,
    output logic      proto_o
);

    localparam bit               C_WDOG_EN  = (TMO_CYC > 0);
    localparam logic [TMO_W-1:0] C_TMO_MAX  = TMO_W'(TMO_CYC);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    e_st_state        state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    // A read retiring the buffer takes priority over a same-cycle ST done.
    always_comb begin
        state_d = state_q;
        proto_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (alloc_pt_i)        state_d = RDY_TO_SA;
                else if (alloc_code_i) state_d = START_STCL;
                proto_o = stcl_i | st_i | rd_i;
            end
            START_STCL: begin
                if (stcl_i) state_d = RDY_TO_SA;
                proto_o = st_i | rd_i;
            end
            RDY_TO_SA: begin
                if (rd_i)      state_d = ST_IDLE;
                else if (st_i) state_d = TBL_RDY_TO_SA;
                proto_o = stcl_i;
            end
            TBL_RDY_TO_SA: begin
                if (rd_i) state_d = ST_IDLE;
                proto_o = stcl_i | st_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && (state_d == START_STCL)) begin
            cnt_d = '0;
        end else if (C_WDOG_EN && (state_q == START_STCL) && (cnt_q != C_TMO_MAX)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Fires on the single cycle in which the counter steps onto the limit.
    assign tmo_o   = C_WDOG_EN && (state_q == START_STCL) && (cnt_q == C_TMO_LAST);
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cr_huf_comp_st_seq.sv
`default_nettype none
// ============================================================================
// cr_huf_comp_st_seq : multi-buffer symbol-table handoff between tree-walk and SA
// Revision: 1.0
// ============================================================================
module cr_huf_comp_st_seq
    import cr_huf_compPKG::*;
#(
    parameter int NUM_BUF = ST_SEQ_NUM_BUF_DFLT,
    parameter int IDX_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = ST_SEQ_TMO_DFLT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tw_pass_thru_rdy_i,
    input  logic                     tw_code_rdy_i,
    input  logic                     st_stcl_lut_wr_done_i,
    input  logic [IDX_W-1:0]         st_stcl_idx_i,
    input  logic                     st_st_lut_wr_done_i,
    input  logic [IDX_W-1:0]         st_st_idx_i,
    input  logic                     sa_st_read_done_i,
    output logic                     st_rdy_o,
    output logic [IDX_W-1:0]         st_wr_idx_o,
    output logic [IDX_W-1:0]         st_rd_idx_o,
    output logic                     st_sa_vld_o,
    output logic                     st_sa_tbl_vld_o,
    output logic [IDX_W:0]           st_occ_o,
    output e_st_state [NUM_BUF-1:0]  st_curr_st_o,
    output logic                     st_err_tmo_o,
    output logic                     st_err_proto_o
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_BUF - 1);

    logic [IDX_W-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [IDX_W:0]          occ_q, occ_d;
    logic                    err_tmo_q, err_proto_q;
    e_st_state [NUM_BUF-1:0] slot_st;
    e_st_state               wr_st, rd_st;
    logic [NUM_BUF-1:0]      alloc_pt, alloc_code, stcl, st, rd, slot_tmo, slot_proto;
    logic                    alloc, rd_ok, rd_bad;

    always_comb begin
        wr_st = ST_IDLE;
        rd_st = ST_IDLE;
        for (int k = 0; k < NUM_BUF; k++) begin
            if (wr_q == IDX_W'(k)) wr_st = slot_st[k];
            if (rd_q == IDX_W'(k)) rd_st = slot_st[k];
        end
    end

    assign st_rdy_o        = (wr_st == ST_IDLE);
    assign st_sa_vld_o     = (rd_st == RDY_TO_SA) || (rd_st == TBL_RDY_TO_SA);
    assign st_sa_tbl_vld_o = (rd_st == TBL_RDY_TO_SA);
    assign alloc           = (tw_pass_thru_rdy_i | tw_code_rdy_i) & st_rdy_o;
    assign rd_ok           = sa_st_read_done_i & st_sa_vld_o;
    assign rd_bad          = sa_st_read_done_i & ~st_sa_vld_o;

    for (genvar k = 0; k < NUM_BUF; k++) begin : g_slot
        assign alloc_pt[k]   = alloc && tw_pass_thru_rdy_i && (wr_q == IDX_W'(k));
        assign alloc_code[k] = alloc && !tw_pass_thru_rdy_i && (wr_q == IDX_W'(k));
        assign stcl[k]       = st_stcl_lut_wr_done_i && (st_stcl_idx_i == IDX_W'(k));
        assign st[k]         = st_st_lut_wr_done_i && (st_st_idx_i == IDX_W'(k));
        assign rd[k]         = rd_ok && (rd_q == IDX_W'(k));

        cr_huf_comp_st_slot #(
            .TMO_W   (TMO_W),
            .TMO_CYC (TMO_CYC)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .alloc_pt_i   (alloc_pt[k]),
            .alloc_code_i (alloc_code[k]),
            .stcl_i       (stcl[k]),
            .st_i         (st[k]),
            .rd_i         (rd[k]),
            .state_o      (slot_st[k]),
            .tmo_o        (slot_tmo[k]),
            .proto_o      (slot_proto[k])
        );
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (alloc) wr_d = (wr_q == C_LAST_IDX) ? '0 : wr_q + IDX_W'(1);
        if (rd_ok) rd_d = (rd_q == C_LAST_IDX) ? '0 : rd_q + IDX_W'(1);
        case ({alloc, rd_ok})
            2'b10:   occ_d = occ_q + (IDX_W+1)'(1);
            2'b01:   occ_d = occ_q - (IDX_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            occ_q       <= '0;
            err_tmo_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
            err_tmo_q   <= err_tmo_q | (|slot_tmo);
            err_proto_q <= err_proto_q | (|slot_proto) | rd_bad;
        end
    end

    assign st_wr_idx_o    = wr_q;
    assign st_rd_idx_o    = rd_q;
    assign st_occ_o       = occ_q;
    assign st_curr_st_o   = slot_st;
    assign st_err_tmo_o   = err_tmo_q;
    assign st_err_proto_o = err_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_st_seq.sv
`default_nettype none
// ============================================================================
// tb_cr_huf_comp_st_seq : directed and randomized checks on 1-, 2- and 4-buffer builds
// Revision: 1.0
// ============================================================================
module tb_cr_huf_comp_st_seq;
    import cr_huf_compPKG::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // NUM_BUF=1 instance
    logic pt1 = 0, code1 = 0, stcl1 = 0, st1 = 0, rd1 = 0;
    logic [0:0] stcl_idx1 = '0, st_idx1 = '0;
    logic rdy1, vld1, tvld1, etmo1, eproto1;
    logic [0:0] wr1, rdi1;
    logic [1:0] occ1;
    e_st_state [0:0] cur1;

    // NUM_BUF=2, TMO_CYC=8 instance
    logic pt2 = 0, code2 = 0, stcl2 = 0, st2 = 0, rd2 = 0;
    logic [0:0] stcl_idx2 = '0, st_idx2 = '0;
    logic rdy2, vld2, tvld2, etmo2, eproto2;
    logic [0:0] wr2, rdi2;
    logic [1:0] occ2;
    e_st_state [1:0] cur2;

    // NUM_BUF=4, watchdog off
    logic pt4 = 0, code4 = 0, stcl4 = 0, st4 = 0, rd4 = 0;
    logic [1:0] stcl_idx4 = '0, st_idx4 = '0;
    logic rdy4, vld4, tvld4, etmo4, eproto4;
    logic [1:0] wr4, rdi4;
    logic [2:0] occ4;
    e_st_state [3:0] cur4;

    cr_huf_comp_st_seq #(.NUM_BUF(1), .TMO_W(16), .TMO_CYC(4096)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .tw_pass_thru_rdy_i(pt1), .tw_code_rdy_i(code1),
        .st_stcl_lut_wr_done_i(stcl1), .st_stcl_idx_i(stcl_idx1),
        .st_st_lut_wr_done_i(st1), .st_st_idx_i(st_idx1),
        .sa_st_read_done_i(rd1),
        .st_rdy_o(rdy1), .st_wr_idx_o(wr1), .st_rd_idx_o(rdi1),
        .st_sa_vld_o(vld1), .st_sa_tbl_vld_o(tvld1), .st_occ_o(occ1),
        .st_curr_st_o(cur1), .st_err_tmo_o(etmo1), .st_err_proto_o(eproto1)
    );

    cr_huf_comp_st_seq #(.NUM_BUF(2), .TMO_W(16), .TMO_CYC(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .tw_pass_thru_rdy_i(pt2), .tw_code_rdy_i(code2),
        .st_stcl_lut_wr_done_i(stcl2), .st_stcl_idx_i(stcl_idx2),
        .st_st_lut_wr_done_i(st2), .st_st_idx_i(st_idx2),
        .sa_st_read_done_i(rd2),
        .st_rdy_o(rdy2), .st_wr_idx_o(wr2), .st_rd_idx_o(rdi2),
        .st_sa_vld_o(vld2), .st_sa_tbl_vld_o(tvld2), .st_occ_o(occ2),
        .st_curr_st_o(cur2), .st_err_tmo_o(etmo2), .st_err_proto_o(eproto2)
    );

    cr_huf_comp_st_seq #(.NUM_BUF(4), .TMO_W(16), .TMO_CYC(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .tw_pass_thru_rdy_i(pt4), .tw_code_rdy_i(code4),
        .st_stcl_lut_wr_done_i(stcl4), .st_stcl_idx_i(stcl_idx4),
        .st_st_lut_wr_done_i(st4), .st_st_idx_i(st_idx4),
        .sa_st_read_done_i(rd4),
        .st_rdy_o(rdy4), .st_wr_idx_o(wr4), .st_rd_idx_o(rdi4),
        .st_sa_vld_o(vld4), .st_sa_tbl_vld_o(tvld4), .st_occ_o(occ4),
        .st_curr_st_o(cur4), .st_err_tmo_o(etmo4), .st_err_proto_o(eproto4)
    );

    // Reference for the 4-buffer build: per-buffer state plus an allocation-order queue
    e_st_state m4 [4];
    e_st_state nm [4];
    int        q [$];
    int        m_alloc;
    int        m_read;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag);
        int        busy = 0;
        e_st_state rs;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s cur[%0d]", tag, k), 32'(cur4[k]), 32'(m4[k]));
            if (m4[k] != ST_IDLE) busy++;
        end
        rs = m4[m_read % 4];
        chk({tag, " wr_idx"}, 32'(wr4), 32'(m_alloc % 4));
        chk({tag, " rd_idx"}, 32'(rdi4), 32'(m_read % 4));
        chk({tag, " occ_vs_busy"}, 32'(occ4), 32'(busy));
        chk({tag, " occ_vs_queue"}, 32'(occ4), 32'(q.size()));
        chk({tag, " rdy"}, 32'(rdy4), 32'(m4[m_alloc % 4] == ST_IDLE));
        chk({tag, " vld"}, 32'(vld4), 32'((rs == RDY_TO_SA) || (rs == TBL_RDY_TO_SA)));
        chk({tag, " tbl_vld"}, 32'(tvld4), 32'(rs == TBL_RDY_TO_SA));
        chk({tag, " err_tmo"}, 32'(etmo4), 32'(0));
        chk({tag, " err_proto"}, 32'(eproto4), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int k = 0; k < 4; k++) m4[k] = ST_IDLE;
        m_alloc = 0;
        m_read  = 0;

        // Reset values while rst_n is held low
        #12;
        chk("rst rdy2", 32'(rdy2), 32'(1));
        chk("rst vld2", 32'(vld2), 32'(0));
        chk("rst occ2", 32'(occ2), 32'(0));
        chk("rst wr2", 32'(wr2), 32'(0));
        chk("rst rd2", 32'(rdi2), 32'(0));
        chk("rst cur2[0]", 32'(cur2[0]), 32'(ST_IDLE));
        chk("rst cur2[1]", 32'(cur2[1]), 32'(ST_IDLE));
        chk("rst errs2", 32'({etmo2, eproto2}), 32'(0));
        chk("rst rdy1", 32'(rdy1), 32'(1));
        check4("rst4_init");
        rst_n = 1'b1;

        // Single buffer walks the full lifecycle, one event per cycle
        code1 = 1'b1;
        step(); code1 = 1'b0;
        chk("t1 state start", 32'(cur1[0]), 32'(START_STCL));
        chk("t1 occ a", 32'(occ1), 32'(1));
        chk("t1 rdy low", 32'(rdy1), 32'(0));
        stcl1 = 1'b1;
        step(); stcl1 = 1'b0;
        chk("t1 state rdy_to_sa", 32'(cur1[0]), 32'(RDY_TO_SA));
        chk("t1 occ b", 32'(occ1), 32'(1));
        chk("t1 vld", 32'(vld1), 32'(1));
        st1 = 1'b1;
        step(); st1 = 1'b0;
        chk("t1 state tbl", 32'(cur1[0]), 32'(TBL_RDY_TO_SA));
        chk("t1 occ c", 32'(occ1), 32'(1));
        chk("t1 tbl_vld", 32'(tvld1), 32'(1));
        rd1 = 1'b1;
        step(); rd1 = 1'b0;
        chk("t1 state idle", 32'(cur1[0]), 32'(ST_IDLE));
        chk("t1 occ d", 32'(occ1), 32'(0));
        chk("t1 rdy back", 32'(rdy1), 32'(1));
        chk("t1 no proto", 32'(eproto1), 32'(0));

        // Two buffers fill, third request is held off until buf0 frees
        pt2 = 1'b1;
        step();
        chk("t2 buf0 rdy_to_sa", 32'(cur2[0]), 32'(RDY_TO_SA));
        chk("t2 wr after 1", 32'(wr2), 32'(1));
        chk("t2 rdy after 1", 32'(rdy2), 32'(1));
        step();
        chk("t2 buf1 rdy_to_sa", 32'(cur2[1]), 32'(RDY_TO_SA));
        chk("t2 rdy after 2", 32'(rdy2), 32'(0));
        chk("t2 occ full", 32'(occ2), 32'(2));
        chk("t2 wr wrapped", 32'(wr2), 32'(0));
        step();
        chk("t2 held occ", 32'(occ2), 32'(2));
        chk("t2 held no proto", 32'(eproto2), 32'(0));
        rd2 = 1'b1;
        step(); rd2 = 1'b0;
        chk("t2 buf0 freed", 32'(cur2[0]), 32'(ST_IDLE));
        chk("t2 rdy after free", 32'(rdy2), 32'(1));
        chk("t2 rd_idx 1", 32'(rdi2), 32'(1));
        chk("t2 occ after free", 32'(occ2), 32'(1));
        step(); pt2 = 1'b0;
        chk("t2 third into buf0", 32'(cur2[0]), 32'(RDY_TO_SA));
        chk("t2 wr_idx 1", 32'(wr2), 32'(1));
        chk("t2 occ 2 again", 32'(occ2), 32'(2));

        // Read buf1, then read and ST done collide on buf0
        rd2 = 1'b1;
        step();
        chk("t3 buf1 idle", 32'(cur2[1]), 32'(ST_IDLE));
        chk("t3 rd_idx 0", 32'(rdi2), 32'(0));
        st2 = 1'b1; st_idx2 = 1'b0;
        step(); rd2 = 1'b0; st2 = 1'b0;
        chk("t3 collide idle", 32'(cur2[0]), 32'(ST_IDLE));
        chk("t3 collide no proto", 32'(eproto2), 32'(0));
        chk("t3 collide rd_idx", 32'(rdi2), 32'(1));
        chk("t3 occ empty", 32'(occ2), 32'(0));

        // Watchdog: 8 cycles in START_STCL without stcl done
        code2 = 1'b1;
        step(); code2 = 1'b0;
        chk("t4 entry", 32'(cur2[1]), 32'(START_STCL));
        chk("t4 tmo at entry", 32'(etmo2), 32'(0));
        repeat (7) step();
        chk("t4 tmo at 7", 32'(etmo2), 32'(0));
        step();
        chk("t4 tmo at 8", 32'(etmo2), 32'(1));
        chk("t4 still start", 32'(cur2[1]), 32'(START_STCL));
        repeat (3) step();
        chk("t4 tmo sticky", 32'(etmo2), 32'(1));
        stcl2 = 1'b1; stcl_idx2 = 1'b1;
        step(); stcl2 = 1'b0;
        chk("t4 late stcl", 32'(cur2[1]), 32'(RDY_TO_SA));
        chk("t4 tmo remains", 32'(etmo2), 32'(1));
        chk("t4 no proto", 32'(eproto2), 32'(0));

        // Protocol errors
        rd2 = 1'b1;
        step(); rd2 = 1'b0;
        chk("t5 buf1 idle", 32'(cur2[1]), 32'(ST_IDLE));
        chk("t5 clean before", 32'(eproto2), 32'(0));
        stcl2 = 1'b1; stcl_idx2 = 1'b1;
        step(); stcl2 = 1'b0;
        chk("t5 stcl idle proto", 32'(eproto2), 32'(1));
        chk("t5 stcl idle state", 32'(cur2[1]), 32'(ST_IDLE));
        rd1 = 1'b1;
        step(); rd1 = 1'b0;
        chk("t5 read no vld proto", 32'(eproto1), 32'(1));
        chk("t5 read no vld state", 32'(cur1[0]), 32'(ST_IDLE));
        chk("t5 read no vld occ", 32'(occ1), 32'(0));
        step();
        chk("t5 proto sticky", 32'(eproto1), 32'(1));

        // Random legal traffic on four buffers with an asynchronous reset mid-stream
        for (int cyc = 0; cyc < 300; cyc++) begin
            int wk, sk, tk, rk;
            wk = m_alloc % 4;
            rk = m_read % 4;
            sk = int'($urandom_range(0, 3));
            tk = int'($urandom_range(0, 3));
            pt4       = ($urandom_range(0, 3) == 0);
            code4     = ($urandom_range(0, 2) == 0);
            stcl_idx4 = 2'(sk);
            st_idx4   = 2'(tk);
            stcl4     = (m4[sk] == START_STCL) && ($urandom_range(0, 1) == 1);
            st4       = (m4[tk] == RDY_TO_SA) && ($urandom_range(0, 1) == 1);
            rd4       = ((m4[rk] == RDY_TO_SA) || (m4[rk] == TBL_RDY_TO_SA)) &&
                        ($urandom_range(0, 2) != 0);
            if (rd4) chk("rand read order", 32'(rdi4), 32'(q[0]));

            nm = m4;
            if ((pt4 || code4) && (m4[wk] == ST_IDLE)) begin
                nm[wk] = pt4 ? RDY_TO_SA : START_STCL;
                q.push_back(wk);
                m_alloc++;
            end
            if (stcl4) nm[sk] = RDY_TO_SA;
            if (st4 && !(rd4 && (rk == tk))) nm[tk] = TBL_RDY_TO_SA;
            if (rd4) begin
                nm[rk] = ST_IDLE;
                void'(q.pop_front());
                m_read++;
            end

            step();
            m4 = nm;
            check4("rand");

            if (cyc == 150) begin
                #2 rst_n = 1'b0;
                #1;
                for (int k = 0; k < 4; k++) m4[k] = ST_IDLE;
                q.delete();
                m_alloc = 0;
                m_read  = 0;
                check4("rst4_mid");
                chk("rst mid err_tmo2", 32'(etmo2), 32'(0));
                chk("rst mid err_proto2", 32'(eproto2), 32'(0));
                chk("rst mid err_proto1", 32'(eproto1), 32'(0));
                #2 rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
